// File: rtl/nios_pio_in_cond.sv
// Input conditioning ahead of the PIO in_port: 2-FF synchronizer, per-bit
// tick-sampled debounce, edge capture with maskable irq, Avalon-MM registers.
module nios_pio_in_cond #(
    parameter int               WIDTH          = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
    parameter logic [15:0]      PRESCALE_RESET = 16'd999
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] pins_in,
    output logic [WIDTH-1:0] data_out
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd1;
    localparam logic [2:0] ADDR_RISE_EN = 3'd2;
    localparam logic [2:0] ADDR_FALL_EN = 3'd3;
    localparam logic [2:0] ADDR_CAPTURE = 3'd4;
    localparam logic [2:0] ADDR_RELOAD  = 3'd5;

    logic [WIDTH-1:0] s1_reg, s2_reg;
    logic [WIDTH-1:0] stable_reg, stable_next;
    logic [WIDTH-1:0] data_out_reg;
    logic [WIDTH-1:0] mask_reg, rise_en_reg, fall_en_reg;
    logic [WIDTH-1:0] capture_reg, capture_next;
    logic [WIDTH-1:0] rise, fall, clr;
    logic [15:0]      reload_reg, count_reg;
    logic             irq_reg;
    logic [31:0]      readdata_reg, readdata_next;
    logic             tick;
    logic             wr;

    assign wr   = chipselect && !write_n;
    assign tick = (count_reg == 16'd0);

    // Metastability chain; s2_reg is the only pin-derived signal used below.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_reg <= '0;
            s2_reg <= '0;
        end else begin
            s1_reg <= pins_in;
            s2_reg <= s1_reg;
        end
    end

    // A reload write only changes the next reload; the running count completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count_reg <= PRESCALE_RESET;
        else if (tick)
            count_reg <= reload_reg;
        else
            count_reg <= count_reg - 16'd1;
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
            logic [2:0] hist_reg;
            logic [2:0] hist_next;

            assign hist_next = {hist_reg[1:0], s2_reg[gi]};

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    hist_reg <= {3{RESET_VALUE[gi]}};
                else if (tick)
                    hist_reg <= hist_next;
            end

            // Stable flips only on a tick whose shifted history is unanimous.
            assign stable_next[gi] = !tick               ? stable_reg[gi] :
                                     (hist_next == 3'b111) ? 1'b1 :
                                     (hist_next == 3'b000) ? 1'b0 :
                                     stable_reg[gi];
        end
    endgenerate

    assign rise = stable_next & ~stable_reg;
    assign fall = ~stable_next & stable_reg;
    assign clr  = (wr && address == ADDR_CAPTURE) ? writedata[WIDTH-1:0] : '0;

    // New edges are OR'd in after the clear so a coincident edge stays set.
    assign capture_next = (capture_reg & ~clr) | (rise & rise_en_reg) | (fall & fall_en_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_reg   <= RESET_VALUE;
            data_out_reg <= RESET_VALUE;
            capture_reg  <= '0;
            irq_reg      <= 1'b0;
        end else begin
            stable_reg   <= stable_next;
            data_out_reg <= stable_reg;
            capture_reg  <= capture_next;
            irq_reg      <= |(capture_reg & mask_reg);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_reg    <= '0;
            rise_en_reg <= '0;
            fall_en_reg <= '0;
            reload_reg  <= PRESCALE_RESET;
        end else if (wr) begin
            case (address)
                ADDR_MASK:    mask_reg    <= writedata[WIDTH-1:0];
                ADDR_RISE_EN: rise_en_reg <= writedata[WIDTH-1:0];
                ADDR_FALL_EN: fall_en_reg <= writedata[WIDTH-1:0];
                ADDR_RELOAD:  reload_reg  <= writedata[15:0];
                default:      ;
            endcase
        end
    end

    always_comb begin
        readdata_next = '0;
        case (address)
            ADDR_DATA:    readdata_next[WIDTH-1:0] = stable_reg;
            ADDR_MASK:    readdata_next[WIDTH-1:0] = mask_reg;
            ADDR_RISE_EN: readdata_next[WIDTH-1:0] = rise_en_reg;
            ADDR_FALL_EN: readdata_next[WIDTH-1:0] = fall_en_reg;
            ADDR_CAPTURE: readdata_next[WIDTH-1:0] = capture_reg;
            ADDR_RELOAD:  readdata_next[15:0]      = reload_reg;
            default:      ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata_reg <= '0;
        else
            readdata_reg <= readdata_next;
    end

    assign readdata = readdata_reg;
    assign irq      = irq_reg;
    assign data_out = data_out_reg;

endmodule

// File: tb/tb_nios_pio_in_cond.sv
// Directed bench for nios_pio_in_cond: reset, debounce latency, prescaler,
// edge capture/irq, set-wins clearing and register readback.
module tb_nios_pio_in_cond;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [31:0] pins_in;
    logic [31:0] data_out;

    int checks = 0;
    int errors = 0;

    nios_pio_in_cond dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .pins_in    (pins_in),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    // All stimulus changes land 1 ns after a rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        $display("write addr=%0d data=0x%08h", a, d);
    endtask

    task automatic do_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        step(1);
        d = readdata;
        $display("read  addr=%0d data=0x%08h", a, d);
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        reset_n    = 1'b0;
        pins_in    = 32'hFFFF_FFFF;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out got=0x%08h exp=0x00000000", data_out); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
        checks++;
        if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got=0x%08h exp=0x00000000", readdata); end
        pins_in = '0;
        reset_n = 1'b1;
        step(1);
        do_read(3'd5, rd);
        checks++;
        if (rd !== 32'h0000_03E7) begin errors++; $display("FAIL reset_reload got=0x%08h exp=0x000003e7", rd); end
        do_read(3'd1, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_mask got=0x%08h exp=0x00000000", rd); end
        // Switch to a tick every clock and let the initial count of 999 drain.
        do_write(3'd5, 32'h0);
        step(1010);
    endtask

    task automatic test_debounce;
        logic changed;
        pins_in[3] = 1'b1;
        step(5);
        checks++;
        if (data_out[3] !== 1'b0) begin errors++; $display("FAIL debounce_early got=%b exp=0 at 5 clk", data_out[3]); end
        step(1);
        checks++;
        if (data_out[3] !== 1'b1) begin errors++; $display("FAIL debounce_latency got=%b exp=1 at 6 clk", data_out[3]); end
        pins_in[3] = 1'b0;
        step(10);
        checks++;
        if (data_out[3] !== 1'b0) begin errors++; $display("FAIL debounce_fall got=%b exp=0", data_out[3]); end
        pins_in[3] = 1'b1;
        step(2);
        pins_in[3] = 1'b0;
        changed = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (data_out[3] !== 1'b0) changed = 1'b1;
        end
        checks++;
        if (changed !== 1'b0) begin errors++; $display("FAIL debounce_glitch got=changed exp=steady 0"); end
    endtask

    task automatic test_edge_irq;
        logic [31:0] rd;
        do_write(3'd2, 32'h1);
        do_write(3'd3, 32'h1);
        do_write(3'd1, 32'h1);
        pins_in[0] = 1'b1;
        step(8);
        do_read(3'd4, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL edge_rise_capture got=0x%08h exp=0x00000001", rd); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL edge_rise_irq got=%b exp=1", irq); end
        do_write(3'd4, 32'h1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_clear_lag got=%b exp=1", irq); end
        step(1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared got=%b exp=0", irq); end
        do_read(3'd4, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL capture_cleared got=0x%08h exp=0x00000000", rd); end
        pins_in[0] = 1'b0;
        step(8);
        do_read(3'd4, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL edge_fall_capture got=0x%08h exp=0x00000001", rd); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL edge_fall_irq got=%b exp=1", irq); end
        do_write(3'd4, 32'h1);
    endtask

    task automatic test_set_wins;
        logic [31:0] rd;
        do_write(3'd2, 32'h21);
        // Pin set now; the stable update of bit 5 happens on the 5th edge.
        pins_in[5] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        address    = 3'd4;
        writedata  = 32'hFFFF_FFFF;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        do_read(3'd4, rd);
        checks++;
        if (rd !== 32'h20) begin errors++; $display("FAIL set_wins got=0x%08h exp=0x00000020", rd); end
        pins_in[5] = 1'b0;
        step(8);
        do_write(3'd4, 32'hFFFF_FFFF);
    endtask

    task automatic test_mask_readback;
        logic [31:0] rd;
        do_write(3'd1, 32'hA5);
        do_write(3'd2, 32'h0F);
        do_write(3'd3, 32'hF0);
        do_read(3'd1, rd);
        checks++;
        if (rd !== 32'hA5) begin errors++; $display("FAIL readback_mask got=0x%08h exp=0x000000a5", rd); end
        do_read(3'd2, rd);
        checks++;
        if (rd !== 32'h0F) begin errors++; $display("FAIL readback_rise_en got=0x%08h exp=0x0000000f", rd); end
        do_read(3'd3, rd);
        checks++;
        if (rd !== 32'hF0) begin errors++; $display("FAIL readback_fall_en got=0x%08h exp=0x000000f0", rd); end
        do_read(3'd6, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL readback_unmapped got=0x%08h exp=0x00000000", rd); end
        do_write(3'd2, 32'h5A);
        do_write(3'd4, 32'hFFFF_FFFF);
        pins_in = 32'h5A;
        step(8);
        do_read(3'd4, rd);
        checks++;
        if (rd !== 32'h5A) begin errors++; $display("FAIL mask_capture got=0x%08h exp=0x0000005a", rd); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL masked_irq got=%b exp=0", irq); end
        do_write(3'd1, 32'h02);
        step(1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL unmasked_irq got=%b exp=1", irq); end
        do_write(3'd1, 32'h0);
        pins_in = '0;
        step(8);
        do_write(3'd4, 32'hFFFF_FFFF);
    endtask

    task automatic test_prescaler;
        logic [31:0] rd;
        int n;
        do_write(3'd5, 32'h4);
        step(10);
        do_read(3'd5, rd);
        checks++;
        if (rd !== 32'h4) begin errors++; $display("FAIL prescale_reload got=0x%08h exp=0x00000004", rd); end
        pins_in[0] = 1'b1;
        n = 0;
        while (data_out[0] === 1'b0 && n < 40) begin
            step(1);
            n++;
        end
        $display("prescaler rise after %0d clk", n);
        checks++;
        if (n < 13 || n > 18) begin errors++; $display("FAIL prescale_latency got=%0d exp=13..18", n); end
    endtask

    task automatic test_reset_midrun;
        logic [31:0] rd;
        do_write(3'd5, 32'h0);
        do_write(3'd2, 32'hFFFF_FFFF);
        do_write(3'd1, 32'hFFFF_FFFF);
        pins_in = 32'hFFFF_FFFF;
        step(12);
        do_read(3'd0, rd);
        checks++;
        if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL pre_reset_data got=0x%08h exp=0xffffffff", rd); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got=%b exp=1", irq); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (data_out !== 32'h0) begin errors++; $display("FAIL midreset_data_out got=0x%08h exp=0x00000000", data_out); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq got=%b exp=0", irq); end
        checks++;
        if (readdata !== 32'h0) begin errors++; $display("FAIL midreset_readdata got=0x%08h exp=0x00000000", readdata); end
        step(1);
        reset_n = 1'b1;
        do_read(3'd5, rd);
        checks++;
        if (rd !== 32'h0000_03E7) begin errors++; $display("FAIL midreset_reload got=0x%08h exp=0x000003e7", rd); end
    endtask

    initial begin
        test_reset;
        test_debounce;
        test_edge_irq;
        test_set_wins;
        test_mask_readback;
        test_prescaler;
        test_reset_midrun;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios_pio_in_cond.md
Name: nios_pio_in_cond

Overview:
- Input-conditioning stage directly upstream of the PIO's in_port.
- Takes raw asynchronous board pins and synchronizes them with a 2-FF chain.
- Debounces each bit on a shared programmable tick and drives the stable value to the PIO in_port.
- Captures qualified edges and raises a maskable interrupt. Register access is through its own Avalon-MM slave with registered readdata (read latency 1), placed on the same Nios bus as the PIO.

Parameters:
- WIDTH, 32, number of input bits (1..32); unused readdata bits read 0.
- RESET_VALUE, 0, value of data_out and the stable register after reset.
- PRESCALE_RESET, 16'd999, reset value of the prescaler reload register.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- irq  out  1  level interrupt, active high
- pins_in  in  WIDTH  raw asynchronous pins
- data_out  out  WIDTH  debounced value; connects to the PIO in_port

Behaviour:
- Reset is asynchronous, active-low on reset_n; clock is clk. All state is reset; there is no synchronous reset.
- Reset values:
  - readdata = 0, irq = 0, data_out = RESET_VALUE.
  - sync FFs = 0; sample shift registers = RESET_VALUE replicated.
  - mask = 0, rise_en = 0, fall_en = 0, capture = 0.
  - reload = PRESCALE_RESET; prescale counter = PRESCALE_RESET.
- Write strobe: wr = chipselect && !write_n, sampled on the clk edge.
- Register map (writes to unlisted addresses are ignored; reads of them return 0):
  - 0 DATA: RO, stable value.
  - 1 MASK: RW.
  - 2 RISE_EN: RW.
  - 3 FALL_EN: RW.
  - 4 CAPTURE: read; write-1-to-clear.
  - 5 RELOAD: RW, bits [15:0]; bits [31:16] read 0.
- Read path:
  - readdata <= mux(address) every clk, independent of chipselect, zero-extended.
  - Value is visible the cycle after address is presented.
- Synchronizer:
  - s1 <= pins_in; s2 <= s1.
  - s2 is the only signal used downstream; raw pins never reach any other logic.
- Prescaler:
  - 16-bit down counter. When counter == 0: tick = 1 for one cycle, counter <= reload. Otherwise counter decrements.
  - reload = 0 gives tick every cycle.
  - A write to RELOAD updates the reload register only; the running count finishes first.
- Per-bit debounce:
  - On tick, hist[i] <= {hist[i][1:0], s2[i]} (3 samples).
  - If hist is all-ones after the shift and stable[i] == 0, stable[i] <= 1; all-zeros with stable[i] == 1 gives stable[i] <= 0. Anything else holds.
  - Worst-case latency from pin change to data_out: 2 clk + 3 ticks + 1 clk.
  - Glitches shorter than one tick period are filtered; stable changes only on the clk after a tick.
- Edge capture:
  - rise[i] = stable[i] goes 0->1; fall[i] = stable[i] goes 1->0 (one-cycle pulses derived from the stable update).
  - capture[i] <= (capture[i] & ~clr[i]) | (rise[i] & rise_en[i]) | (fall[i] & fall_en[i]), where clr = writedata when writing address 4.
  - An edge in the same cycle as a clearing write leaves the bit SET (set wins).
- irq: registered; irq <= |(capture & mask). It asserts 1 clk after capture sets and deasserts 1 clk after the bit is cleared or masked.
- data_out = stable, directly from flops with no combinational path from pins_in.
- Reset mid-debounce discards history; data_out returns to RESET_VALUE immediately (asynchronous).

Test Plan:
- Reset: assert reset_n=0 mid-run with pins_in=32'hFFFF_FFFF → data_out=RESET_VALUE=0, irq=0, readdata=0; after release, read addr 5 → 0x0000_03E7.
- Debounce: reload=0, raise pins_in[3] and hold → data_out[3]=1 exactly 2+3+1=6 clk later. A 2-clk pulse on pins_in[3] → data_out never changes.
- Prescaler: reload=4 (tick every 5 clk), hold pins_in[0]=1 → data_out[0] rises within 2+15+1 clk, and not before 2+10+1 clk.
- Edge/irq:
  - Setup: rise_en=0x1, fall_en=0x1, mask=0x1.
  - Bit 0 rise → read addr 4 → 0x1, irq=1.
  - Write 0x1 to addr 4 → capture=0, irq=0 one clk later.
  - Bit 0 fall → capture=0x1 again.
- Set-wins: time a write of 0xFFFF_FFFF to addr 4 to coincide with a rise update on bit 5 (rise_en[5]=1) → capture[5]=1 afterwards.
- Mask/readback:
  - Write MASK=0xA5, RISE_EN=0x0F, FALL_EN=0xF0; read back each with 1-clk latency. Read addr 6 → 0.
  - capture=0x5A with mask=0xA5 → irq=0.
